// File: rtl/ddr3_rd_gather_if.sv
// rtl/ddr3_rd_gather_if.sv - read-data gather stream bundle: deserializer nibbles in, gathered bursts out
interface ddr3_rd_gather_if #(
  parameter int DQ_WIDTH = 8
);
  logic [4*DQ_WIDTH-1:0] din;
  logic                  rd_start;
  logic [8*DQ_WIDTH-1:0] dout;
  logic                  dout_valid;

  modport master (
    output din,
    output rd_start,
    input  dout,
    input  dout_valid
  );

  modport slave (
    input  din,
    input  rd_start,
    output dout,
    output dout_valid
  );
endinterface

// File: rtl/ddr3_rd_gather.sv
// rtl/ddr3_rd_gather.sv - DDR3 read-side bit-slip alignment, read-latency delay and BL8 gather
module ddr3_rd_gather #(
  parameter int DQ_WIDTH  = 8,
  parameter int LAT_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           bit_sel,
  input  logic [LAT_WIDTH-1:0] rd_lat,
  output logic                 busy,
  output logic                 overrun,
  ddr3_rd_gather_if.slave      bus
);

  localparam int DEPTH = 1 << LAT_WIDTH;

  typedef enum logic [1:0] {IDLE, HALF, DONE} state_t;

  state_t                state;
  state_t                state_nx;
  logic [4*DQ_WIDTH-1:0] din_d;
  logic [4*DQ_WIDTH-1:0] al;
  logic [4*DQ_WIDTH-1:0] al_nx;
  logic [4*DQ_WIDTH-1:0] lo_hold;
  logic [8*DQ_WIDTH-1:0] dout_q;
  logic [8*DQ_WIDTH-1:0] dout_nx;
  logic [DEPTH-1:0]      dline;
  logic [LAT_WIDTH-1:0]  hit_idx;
  logic                  hit;
  logic                  ld_lo;
  logic                  ld_out;
  logic                  set_ovr;
  logic                  overrun_q;

  function automatic logic [3:0] slip(input logic [7:0] w, input logic [1:0] s);
    logic [7:0] t;
    t = w >> s;
    return t[3:0];
  endfunction

  // Older nibble sits in the low half so bit_sel=0 passes the previous cycle unchanged
  always_comb begin
    al_nx   = '0;
    dout_nx = '0;
    for (int l = 0; l < DQ_WIDTH; l++) begin
      al_nx[4*l +: 4]   = slip({bus.din[4*l +: 4], din_d[4*l +: 4]}, bit_sel);
      dout_nx[8*l +: 8] = {al[4*l +: 4], lo_hold[4*l +: 4]};
    end
  end

  // rd_lat of 0 folds onto 1 since the delay line itself costs one stage
  assign hit_idx = (rd_lat == '0) ? '0 : rd_lat - 1'b1;
  assign hit     = dline[hit_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ld_lo    = 1'b0;
    ld_out   = 1'b0;
    set_ovr  = 1'b0;
    case (state)
      IDLE: begin
        if (hit) begin
          ld_lo    = 1'b1;
          state_nx = HALF;
        end
      end
      HALF: begin
        ld_out   = 1'b1;
        set_ovr  = hit;
        state_nx = DONE;
      end
      DONE: begin
        if (hit) begin
          ld_lo    = 1'b1;
          state_nx = HALF;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_d     <= '0;
      al        <= '0;
      dline     <= '0;
      lo_hold   <= '0;
      dout_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      din_d <= bus.din;
      al    <= al_nx;
      dline <= {dline[DEPTH-2:0], bus.rd_start};
      if (ld_lo) begin
        lo_hold <= al;
      end
      // dout is loaded with the high beats so it is complete while DONE strobes
      if (ld_out) begin
        dout_q <= dout_nx;
      end
      if (set_ovr) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = (state == DONE);
  assign busy           = (|dline) | (state != IDLE);
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_ddr3_rd_gather.sv
// tb/tb_ddr3_rd_gather.sv - bench for ddr3_rd_gather: vector table, directed corners, random vs model
module tb_ddr3_rd_gather;

  localparam int DQ = 8;
  localparam int N  = 4096;

  typedef struct {
    logic [1:0] bs;
    logic [4:0] lat;
    logic [3:0] n0;
    logic [3:0] n1;
    logic [3:0] n2;
    logic [7:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] bsel = '0;
  logic [4:0] lat = '0;
  logic       busy;
  logic       overrun;

  int          cyc = 0;
  int          base = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] din_h [N];
  bit          st_h [N];
  bit          acc_h [N];
  bit          drop_h [N];
  logic [63:0] dout_m = '0;
  bit          ovr_m = 1'b0;
  vec_t        vt [8];

  ddr3_rd_gather_if #(.DQ_WIDTH(DQ)) bus ();

  ddr3_rd_gather #(.DQ_WIDTH(DQ), .LAT_WIDTH(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bit_sel (bsel),
    .rd_lat  (lat),
    .busy    (busy),
    .overrun (overrun),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic bit st_at(int c);
    return (c >= base && c >= 0) ? st_h[c] : 1'b0;
  endfunction

  function automatic bit acc_at(int c);
    return (c >= base && c >= 0) ? acc_h[c] : 1'b0;
  endfunction

  function automatic bit drop_at(int c);
    return (c >= base && c >= 0) ? drop_h[c] : 1'b0;
  endfunction

  function automatic logic [31:0] din_at(int c);
    return (c >= base && c >= 0) ? din_h[c] : 32'h0;
  endfunction

  // Aligned nibble seen in cycle c: the serial window of the two nibbles before it, slipped by bit_sel
  function automatic logic [3:0] al_m(int c, int l);
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  w;
    a = din_at(c - 1);
    b = din_at(c - 2);
    w = {a[4*l +: 4], b[4*l +: 4]};
    w = w >> bsel;
    return w[3:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_dout"}, bus.dout, 64'h0);
    chk({nm, "_valid"}, 64'(bus.dout_valid), 64'h0);
    chk({nm, "_busy"}, 64'(busy), 64'h0);
    chk({nm, "_overrun"}, 64'(overrun), 64'h0);
  endtask

  task automatic step(input logic [31:0] d, input logic s, input logic r);
    int  eff;
    bit  vexp;
    bit  bexp;
    bit  h;
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= N) begin
      $display("FAIL cycle_budget cycle=%0d limit=%0d", cyc, N);
      $fatal(1);
    end
    bus.din      = d;
    bus.rd_start = s;
    rst_n        = r;
    din_h[cyc]   = d;
    st_h[cyc]    = s;
    acc_h[cyc]   = 1'b0;
    drop_h[cyc]  = 1'b0;
    if (!r) begin
      base   = cyc + 1;
      dout_m = '0;
      ovr_m  = 1'b0;
    end
    @(negedge clk);
    if (!r) begin
      chk_zero("in_reset");
    end else begin
      if (drop_at(cyc - 1)) ovr_m = 1'b1;
      vexp = acc_at(cyc - 2);
      if (vexp) begin
        for (int l = 0; l < DQ; l++) dout_m[8*l +: 8] = {al_m(cyc - 1, l), al_m(cyc - 2, l)};
      end
      bexp = acc_at(cyc - 1) || acc_at(cyc - 2);
      for (int k = 1; k <= 32; k++) if (st_at(cyc - k)) bexp = 1'b1;
      chk("model_valid", 64'(bus.dout_valid), 64'(vexp));
      chk("model_dout", bus.dout, dout_m);
      chk("model_busy", 64'(busy), 64'(bexp));
      chk("model_overrun", 64'(overrun), 64'(ovr_m));
      eff = (lat == 0) ? 1 : int'(lat);
      h = st_at(cyc - eff);
      acc_h[cyc]  = h && !acc_at(cyc - 1);
      drop_h[cyc] = h && acc_at(cyc - 1);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(32'h0, 1'b0, 1'b1);
  endtask

  task automatic assert_reset();
    rst_n  = 1'b0;
    base   = cyc + 1;
    dout_m = '0;
    ovr_m  = 1'b0;
    #1;
    chk_zero("async_reset");
  endtask

  task automatic run_vec(input vec_t v);
    int c0;
    int s;
    int t0;
    int nv;
    int L;
    logic [31:0] d;
    bsel = v.bs;
    lat  = v.lat;
    L    = (v.lat == 0) ? 1 : int'(v.lat);
    c0   = cyc + 1;
    s    = c0 + 2;
    t0   = s + L;
    nv   = 0;
    for (int c = c0; c <= t0 + 4; c++) begin
      d = (c == t0 - 2) ? {DQ{v.n0}} : (c == t0 - 1) ? {DQ{v.n1}} : (c == t0) ? {DQ{v.n2}} : 32'h0;
      step(d, c == s, 1'b1);
      if (bus.dout_valid) nv++;
      if (c == t0 + 2) begin
        chk("vec_valid", 64'(bus.dout_valid), 64'h1);
        chk("vec_dout", bus.dout, {DQ{v.exp}});
      end
    end
    chk("vec_strobes", 64'(nv), 64'h1);
    idle(40);
  endtask

  initial begin
    int c0;
    int nv;

    vt[0] = '{bs: 2'd0, lat: 5'd4,  n0: 4'hA, n1: 4'h5, n2: 4'h0, exp: 8'h5A};
    vt[1] = '{bs: 2'd0, lat: 5'd3,  n0: 4'hF, n1: 4'h0, n2: 4'hF, exp: 8'h0F};
    vt[2] = '{bs: 2'd1, lat: 5'd3,  n0: 4'hF, n1: 4'h0, n2: 4'hF, exp: 8'h87};
    vt[3] = '{bs: 2'd2, lat: 5'd3,  n0: 4'hF, n1: 4'h0, n2: 4'hF, exp: 8'hC3};
    vt[4] = '{bs: 2'd3, lat: 5'd3,  n0: 4'hF, n1: 4'h0, n2: 4'hF, exp: 8'hE1};
    vt[5] = '{bs: 2'd1, lat: 5'd7,  n0: 4'h3, n1: 4'hC, n2: 4'h6, exp: 8'h61};
    vt[6] = '{bs: 2'd0, lat: 5'd0,  n0: 4'hA, n1: 4'h5, n2: 4'h0, exp: 8'h5A};
    vt[7] = '{bs: 2'd3, lat: 5'd31, n0: 4'h8, n1: 4'h1, n2: 4'h2, exp: 8'h43};

    bus.din      = '0;
    bus.rd_start = 1'b0;
    step(32'h0, 1'b0, 1'b0);
    step(32'h0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) run_vec(vt[i]);
    vt[6].lat = 5'd1;
    run_vec(vt[6]);

    // Back-to-back commands two cycles apart
    bsel = 2'd0;
    lat  = 5'd6;
    c0   = cyc + 1;
    nv   = 0;
    for (int c = c0; c <= c0 + 20; c++) begin
      step($urandom, (c == c0) || (c == c0 + 2) || (c == c0 + 4), 1'b1);
      if (bus.dout_valid) nv++;
      if (c == c0 + 8 || c == c0 + 10 || c == c0 + 12) chk("b2b_valid", 64'(bus.dout_valid), 64'h1);
    end
    chk("b2b_strobes", 64'(nv), 64'h3);
    chk("b2b_overrun", 64'(overrun), 64'h0);
    idle(40);

    // Commands one cycle apart: second is dropped
    c0 = cyc + 1;
    nv = 0;
    for (int c = c0; c <= c0 + 20; c++) begin
      step($urandom, (c == c0) || (c == c0 + 1), 1'b1);
      if (bus.dout_valid) nv++;
    end
    chk("ovr_strobes", 64'(nv), 64'h1);
    chk("ovr_flag", 64'(overrun), 64'h1);
    idle(40);
    chk("ovr_sticky", 64'(overrun), 64'h1);
    chk("ovr_busy_low", 64'(busy), 64'h0);

    // Reset while the FSM is in HALF
    step(32'h0, 1'b0, 1'b0);
    lat = 5'd4;
    c0  = cyc + 1;
    for (int c = c0; c <= c0 + 5; c++) step($urandom, c == c0, 1'b1);
    chk("half_busy", 64'(busy), 64'h1);
    assert_reset();
    for (int i = 0; i < 3; i++) step(32'h0, 1'b0, 1'b0);
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      step(32'h0, 1'b0, 1'b1);
      if (bus.dout_valid) nv++;
    end
    chk("post_reset_no_strobe", 64'(nv), 64'h0);
    run_vec(vt[0]);

    for (int seg = 0; seg < 6; seg++) begin
      if ($urandom % 2 == 0) begin
        step(32'h0, 1'b0, 1'b0);
        step(32'h0, 1'b0, 1'b0);
      end
      bsel = 2'($urandom);
      lat  = 5'($urandom);
      for (int i = 0; i < 300; i++) step($urandom, ($urandom % 4) == 0, 1'b1);
      idle(40);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
